// File: rtl/mult_pkg.sv
// mult_pkg: shared width, iteration count and state encoding for the Booth multiplier.
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = 32;
  localparam int MULT_CNT_W = $clog2(MULT_ITERS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mult_booth_decode.sv
// booth_decode: radix-2 Booth recoding of {Q[0], q_1} into add/subtract enables.
module booth_decode (
  input  logic i_q0,
  input  logic i_q1,
  output logic o_add_en,
  output logic o_sub_en
);
  assign o_add_en = ~i_q0 & i_q1;
  assign o_sub_en = i_q0 & ~i_q1;
endmodule

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: 32-cycle signed radix-2 Booth multiplier driving a shared external adder.
// MULT_OVF_EN enables the signed 32-bit overflow exception; otherwise data_exception is 0.
module mult_booth_seq
  import mult_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_mult,
  input  logic [MULT_WIDTH-1:0] data_operandA,
  input  logic [MULT_WIDTH-1:0] data_operandB,
  output logic [MULT_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic                  busy,
  output logic [MULT_WIDTH-1:0] add_x,
  output logic [MULT_WIDTH-1:0] add_y,
  output logic                  add_cin,
  input  logic [MULT_WIDTH-1:0] add_sum,
  input  logic                  add_ovf
);
  localparam int PW = 2 * MULT_WIDTH + 1;
  state_t                r_state, w_next;
  logic [PW-1:0]         r_p, w_p_next;
  logic [MULT_WIDTH-1:0] r_m, r_result;
  logic [MULT_CNT_W-1:0] r_cnt;
  logic                  r_exc, w_exc, w_run, w_start, w_last, w_add_en, w_sub_en, w_sgn;

  assign w_run   = (r_state == RUN);
  assign w_start = ctrl_mult && !w_run;
  assign w_last  = w_run && (r_cnt == MULT_CNT_W'(MULT_ITERS - 1));

  booth_decode u_dec (
    .i_q0    (r_p[1]),
    .i_q1    (r_p[0]),
    .o_add_en(w_add_en),
    .o_sub_en(w_sub_en)
  );

  assign add_x   = w_run ? r_p[PW-1:MULT_WIDTH+1] : '0;
  assign add_y   = !w_run ? '0 : w_sub_en ? ~r_m : w_add_en ? r_m : '0;
  assign add_cin = w_run & w_sub_en;
  // The adder's overflow flag recovers the true 33-bit sign of ACC +/- M.
  assign w_sgn    = add_sum[MULT_WIDTH-1] ^ add_ovf;
  assign w_p_next = {w_sgn, add_sum, r_p[MULT_WIDTH:1]};

`ifdef MULT_OVF_EN
  assign w_exc = (w_p_next[PW-1:MULT_WIDTH+1] != {MULT_WIDTH{w_p_next[MULT_WIDTH]}});
`else
  assign w_exc = 1'b0;
`endif

  always_comb begin
    w_next = w_start ? RUN : w_last ? DONE : (r_state == DONE) ? IDLE : r_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_m   <= data_operandA;
      r_p   <= {{MULT_WIDTH{1'b0}}, data_operandB, 1'b0};
      r_cnt <= '0;
    end else if (w_run) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_p_next[MULT_WIDTH:1];
        r_exc    <= w_exc;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == DONE);
  assign busy           = w_run;
endmodule
